// File: rtl/fetch_pkg.sv
// Shared defaults and state encoding for the instruction fetch unit.
// Imported by fetch_pc_counter and instruction_fetch_unit.
package fetch_pkg;

  localparam int ADDR_W_DEF   = 6;
  localparam int INSTR_W_DEF  = 32;
  localparam int RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_counter.sv
// Program counter: branch load beats increment (wraps) beats hold.
// Ports: clk, rst_n (sync, active-low), load, load_val, inc -> pc.
module fetch_pc_counter
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= ADDR_W'(RESET_PC);
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: PC -> imem, one-entry valid/ready slot to decode.
// Ports: clk, rst_n (sync, active-low), start, halt_req, branch_taken,
// branch_target, imem_addr, imem_data, instr_out, pc_out, instr_valid,
// instr_ready, busy; fetch_count only when FETCH_COUNT_EN is defined.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               halt_req,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]        fetch_count
`endif
);

  fetch_state_t state, state_d;

  logic [ADDR_W-1:0] pc;
  logic slot_free;
  logic xfer;
  logic load;
  logic valid_d;

  assign slot_free = !instr_valid || instr_ready;
  assign xfer      = instr_valid && instr_ready;
  // halt and branch both suppress the load in their cycle
  assign load      = (state == RUN) && !halt_req
                     && !branch_taken && slot_free;
  assign imem_addr = pc;

  fetch_pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (branch_taken),
    .load_val (branch_target),
    .inc      (load),
    .pc       (pc)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (halt_req) state_d = HALTED;
      HALTED:  if (start)    state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = instr_valid;
    if (branch_taken) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_d;
      busy        <= (state_d == RUN);
      instr_valid <= valid_d;
      if (load) begin
        instr_out <= imem_data;
        pc_out    <= pc;
      end
    end
  end

`ifdef FETCH_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (xfer && (fetch_count != 16'hFFFF)) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end
`endif

endmodule
